// File: rtl/obi_hci_responder.sv
// OBI subordinate for the core data port: forwards L1-window accesses to one HCI/TCDM
// initiator port, answers out-of-window accesses locally with an error, and keeps responses in order.
module obi_hci_responder #(
    parameter int unsigned              ADDR_W    = 32,
    parameter int unsigned              DATA_W    = 32,
    parameter int unsigned              RID_W     = 1,
    parameter int unsigned              N_OUTST   = 2,
    parameter logic [ADDR_W-1:0]        WIN_START = 32'h1000_0000,
    parameter logic [ADDR_W-1:0]        WIN_END   = 32'h2000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // OBI A channel
    input  logic                  obi_req_i,
    output logic                  obi_gnt_o,
    input  logic [ADDR_W-1:0]     obi_addr_i,
    input  logic                  obi_we_i,
    input  logic [DATA_W/8-1:0]   obi_be_i,
    input  logic [DATA_W-1:0]     obi_wdata_i,
    input  logic [RID_W-1:0]      obi_aid_i,
    // OBI R channel
    output logic                  obi_rvalid_o,
    output logic [DATA_W-1:0]     obi_rdata_o,
    output logic [RID_W-1:0]      obi_rid_o,
    output logic                  obi_err_o,
    // HCI initiator
    output logic                  hci_req_o,
    input  logic                  hci_gnt_i,
    output logic [ADDR_W-1:0]     hci_add_o,
    output logic                  hci_wen_o,
    output logic [DATA_W/8-1:0]   hci_be_o,
    output logic [DATA_W-1:0]     hci_data_o,
    input  logic                  hci_r_valid_i,
    input  logic [DATA_W-1:0]     hci_r_data_i,
    // status
    output logic                  proto_err_o
);

    localparam int unsigned PTR_W = (N_OUTST > 1) ? $clog2(N_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(N_OUTST + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_OUTST - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_OUTST);

    typedef struct packed {
        logic [RID_W-1:0] rid;
        logic             we;
        logic             err;
    } tag_t;

    tag_t             tag_mem_q [N_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [RID_W-1:0]  rid_q, rid_d;
    logic              err_q, err_d;
    logic              proto_err_q, proto_err_d;

    logic in_win, full, empty, gnt, push, pop, stray;
    tag_t head;

    // HCI request fields are pure pass-throughs of the OBI A channel.
    assign hci_add_o  = obi_addr_i;
    assign hci_wen_o  = ~obi_we_i;
    assign hci_be_o   = obi_be_i;
    assign hci_data_o = obi_wdata_i;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct here, '<=' belongs in always_ff.
    always_comb begin
        in_win = (obi_addr_i >= WIN_START) && (obi_addr_i < WIN_END);
        full   = (count_q == CNT_FULL);
        empty  = (count_q == '0);
        head   = tag_mem_q[rd_ptr_q];

        // Full blocks the grant even if a pop frees a slot this cycle: keeps gnt off the response path.
        gnt       = obi_req_i & ~full & (in_win ? hci_gnt_i : 1'b1);
        hci_req_o = obi_req_i & in_win & ~full;
        obi_gnt_o = gnt;
        push      = obi_req_i & gnt;

        pop   = ~empty & (head.err | hci_r_valid_i);
        stray = hci_r_valid_i & (empty | head.err);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        err_d    = err_q;
        if (pop) begin
            rvalid_d = 1'b1;
            rid_d    = head.rid;
            err_d    = head.err;
            rdata_d  = (head.err | head.we) ? '0 : hci_r_data_i;
        end

        proto_err_d = proto_err_q | stray;
    end

    // NOTE: the tag storage is deliberately left out of reset; the pointers and occupancy
    // counter decide validity, so clearing the array would only cost flops and reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= '{rid: obi_aid_i, we: obi_we_i, err: ~in_win};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rid_q       <= '0;
            err_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rid_q       <= rid_d;
            err_q       <= err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign obi_rvalid_o = rvalid_q;
    assign obi_rdata_o  = rdata_q;
    assign obi_rid_o    = rid_q;
    assign obi_err_o    = err_q;
    assign proto_err_o  = proto_err_q;

endmodule

// File: tb/tb_obi_hci_responder.sv
// Directed bench for obi_hci_responder (default parameters, N_OUTST=2, TCDM latency 1).
module tb_obi_hci_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [0:0]  obi_aid_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic [0:0]  obi_rid_o;
    logic        obi_err_o;
    logic        hci_req_o;
    logic        hci_gnt_i;
    logic [31:0] hci_add_o;
    logic        hci_wen_o;
    logic [3:0]  hci_be_o;
    logic [31:0] hci_data_o;
    logic        hci_r_valid_i;
    logic [31:0] hci_r_data_i;
    logic        proto_err_o;

    int vectors     = 0;
    int miscompares = 0;

    // response bundle {rvalid, err, rid, rdata}
    logic [34:0] got_r, exp_r;
    // A-channel bundle {gnt, hci_req}
    logic [1:0]  got_a, exp_a;

    obi_hci_responder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .obi_req_i     (obi_req_i),
        .obi_gnt_o     (obi_gnt_o),
        .obi_addr_i    (obi_addr_i),
        .obi_we_i      (obi_we_i),
        .obi_be_i      (obi_be_i),
        .obi_wdata_i   (obi_wdata_i),
        .obi_aid_i     (obi_aid_i),
        .obi_rvalid_o  (obi_rvalid_o),
        .obi_rdata_o   (obi_rdata_o),
        .obi_rid_o     (obi_rid_o),
        .obi_err_o     (obi_err_o),
        .hci_req_o     (hci_req_o),
        .hci_gnt_i     (hci_gnt_i),
        .hci_add_o     (hci_add_o),
        .hci_wen_o     (hci_wen_o),
        .hci_be_o      (hci_be_o),
        .hci_data_o    (hci_data_o),
        .hci_r_valid_i (hci_r_valid_i),
        .hci_r_data_i  (hci_r_data_i),
        .proto_err_o   (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [0:0] aid,
                             input logic [31:0] wdata, input logic [3:0] be);
        obi_req_i   = 1'b1;
        obi_addr_i  = addr;
        obi_we_i    = we;
        obi_aid_i   = aid;
        obi_wdata_i = wdata;
        obi_be_i    = be;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        obi_req_i     = 1'b0;
        obi_addr_i    = '0;
        obi_we_i      = 1'b0;
        obi_be_i      = '0;
        obi_wdata_i   = '0;
        obi_aid_i     = '0;
        hci_gnt_i     = 1'b0;
        hci_r_valid_i = 1'b0;
        hci_r_data_i  = '0;
        #2;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        vectors++;
        if ({got_r, proto_err_o} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%b expected 0/0", got_r, proto_err_o);
        end
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        // Combinational grant straight out of reset; request dropped again before the edge.
        drive_req(32'h1000_0000, 1'b0, 1'b0, 32'h0, 4'hF);
        hci_gnt_i = 1'b0;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_gnt_hold: got %b expected 01", got_a);
        end
        hci_gnt_i = 1'b1;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_gnt_pass: got %b expected 11", got_a);
        end
        // Window boundaries, checked combinationally with the HCI grant low.
        hci_gnt_i  = 1'b0;
        obi_addr_i = 32'h0FFF_FFFF;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b10) begin
            miscompares++;
            $display("FAIL below_window: got %b expected 10", got_a);
        end
        obi_addr_i = 32'h1FFF_FFFF;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b01) begin
            miscompares++;
            $display("FAIL window_top: got %b expected 01", got_a);
        end
        obi_req_i = 1'b0;
    endtask

    task automatic test_single_read();
        tick();
        drive_req(32'h1000_0010, 1'b0, 1'b1, 32'h0, 4'hF);
        hci_gnt_i = 1'b1;
        #1;
        vectors++;
        if ({obi_gnt_o, hci_req_o, hci_wen_o, hci_add_o} !== {3'b111, 32'h1000_0010}) begin
            miscompares++;
            $display("FAIL single_read_a: got %b%b%b %h expected 111 10000010",
                     obi_gnt_o, hci_req_o, hci_wen_o, hci_add_o);
        end
        tick();
        obi_req_i     = 1'b0;
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (obi_rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL single_read_early: got rvalid %b expected 0", obi_rvalid_o);
        end
        tick();
        hci_r_valid_i = 1'b0;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL single_read_resp: got %h expected %h", got_r, exp_r);
        end
        tick();
        vectors++;
        if ({obi_rvalid_o, obi_rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL single_read_pulse: got %b %h expected 0 deadbeef", obi_rvalid_o, obi_rdata_o);
        end
    endtask

    task automatic test_out_of_window();
        drive_req(32'h2000_0000, 1'b0, 1'b0, 32'h0, 4'hF);
        hci_gnt_i = 1'b0;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b10) begin
            miscompares++;
            $display("FAIL oow_grant: got %b expected 10", got_a);
        end
        tick();
        obi_req_i = 1'b0;
        #1;
        vectors++;
        if (obi_rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL oow_early: got rvalid %b expected 0", obi_rvalid_o);
        end
        tick();
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b1, 1'b0, 32'h0};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL oow_resp: got %h expected %h", got_r, exp_r);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        hci_gnt_i = 1'b1;
        drive_req(32'h1000_0100, 1'b0, 1'b0, 32'h0, 4'hF);
        #1;
        vectors++;
        if (obi_gnt_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_gnt: got %b expected 1", obi_gnt_o);
        end
        tick();
        drive_req(32'h1000_0104, 1'b0, 1'b1, 32'h0, 4'hF);
        #1;
        vectors++;
        if (obi_gnt_o !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_gnt: got %b expected 1", obi_gnt_o);
        end
        tick();
        drive_req(32'h1000_0108, 1'b0, 1'b0, 32'h0, 4'hF);
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_full_block: got %b expected 00", got_a);
        end
        tick();
        // First response arrives; pop this cycle must not open the grant yet.
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'h1111_1111;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_full_on_pop: got %b expected 00", got_a);
        end
        tick();
        hci_r_data_i = 32'h2222_2222;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_third_gnt: got %b expected 11", got_a);
        end
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b0, 32'h1111_1111};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL b2b_resp0: got %h expected %h", got_r, exp_r);
        end
        tick();
        obi_req_i    = 1'b0;
        hci_r_data_i = 32'h3333_3333;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b1, 32'h2222_2222};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL b2b_resp1: got %h expected %h", got_r, exp_r);
        end
        tick();
        hci_r_valid_i = 1'b0;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b0, 32'h3333_3333};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL b2b_resp2: got %h expected %h", got_r, exp_r);
        end
        tick();
        vectors++;
        if ({obi_rvalid_o, proto_err_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_drained: got %b%b expected 00", obi_rvalid_o, proto_err_o);
        end
    endtask

    task automatic test_mixed_order();
        hci_gnt_i = 1'b1;
        drive_req(32'h1000_0200, 1'b0, 1'b0, 32'h0, 4'hF);
        tick();
        drive_req(32'h3000_0000, 1'b1, 1'b1, 32'h5555_AAAA, 4'hF);
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'hCAFE_F00D;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b10) begin
            miscompares++;
            $display("FAIL mixed_oow_a: got %b expected 10", got_a);
        end
        tick();
        drive_req(32'h1000_0204, 1'b1, 1'b0, 32'h1234_5678, 4'b0011);
        hci_r_valid_i = 1'b0;
        #1;
        vectors++;
        if ({obi_gnt_o, hci_wen_o, hci_be_o, hci_data_o} !== {2'b10, 4'b0011, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL mixed_wr_a: got %b%b %b %h expected 10 0011 12345678",
                     obi_gnt_o, hci_wen_o, hci_be_o, hci_data_o);
        end
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b0, 32'hCAFE_F00D};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL mixed_resp0: got %h expected %h", got_r, exp_r);
        end
        tick();
        obi_req_i     = 1'b0;
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'hFFFF_FFFF;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b1, 1'b1, 32'h0};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL mixed_resp1: got %h expected %h", got_r, exp_r);
        end
        tick();
        hci_r_valid_i = 1'b0;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b0, 32'h0};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL mixed_resp2: got %h expected %h", got_r, exp_r);
        end
        tick();
        vectors++;
        if ({obi_rvalid_o, proto_err_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL mixed_drained: got %b%b expected 00", obi_rvalid_o, proto_err_o);
        end
    endtask

    task automatic test_backpressure();
        hci_gnt_i = 1'b0;
        drive_req(32'h1000_0300, 1'b0, 1'b1, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if ({obi_gnt_o, hci_req_o, hci_add_o} !== {2'b01, 32'h1000_0300}) begin
                miscompares++;
                $display("FAIL backpressure_cycle%0d: got %b%b %h expected 01 10000300",
                         c, obi_gnt_o, hci_req_o, hci_add_o);
            end
            tick();
        end
        hci_gnt_i = 1'b1;
        #1;
        got_a = {obi_gnt_o, hci_req_o};
        vectors++;
        if (got_a !== 2'b11) begin
            miscompares++;
            $display("FAIL backpressure_release: got %b expected 11", got_a);
        end
        tick();
        obi_req_i     = 1'b0;
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'hA5A5_A5A5;
        tick();
        hci_r_valid_i = 1'b0;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL backpressure_resp: got %h expected %h", got_r, exp_r);
        end
        tick();
    endtask

    task automatic test_proto_err_reset();
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'h0BAD_0BAD;
        tick();
        hci_r_valid_i = 1'b0;
        vectors++;
        if ({proto_err_o, obi_rvalid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL proto_err_set: got %b%b expected 10", proto_err_o, obi_rvalid_o);
        end
        tick();
        vectors++;
        if (proto_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL proto_err_sticky: got %b expected 1", proto_err_o);
        end
        // Out-of-window read then an in-window read left outstanding.
        hci_gnt_i = 1'b1;
        drive_req(32'h4000_0000, 1'b0, 1'b1, 32'h0, 4'hF);
        tick();
        drive_req(32'h1000_0400, 1'b0, 1'b0, 32'h0, 4'hF);
        tick();
        obi_req_i = 1'b0;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        exp_r = {1'b1, 1'b1, 1'b1, 32'h0};
        vectors++;
        if (got_r !== exp_r) begin
            miscompares++;
            $display("FAIL pre_reset_resp: got %h expected %h", got_r, exp_r);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        got_r = {obi_rvalid_o, obi_err_o, obi_rid_o, obi_rdata_o};
        vectors++;
        if ({got_r, proto_err_o} !== 36'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h/%b expected 0/0", got_r, proto_err_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        // The in-window tag was discarded, so its late response is a stray.
        hci_r_valid_i = 1'b1;
        hci_r_data_i  = 32'h7777_7777;
        tick();
        hci_r_valid_i = 1'b0;
        vectors++;
        if ({proto_err_o, obi_rvalid_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL stray_after_reset: got %b%b expected 10", proto_err_o, obi_rvalid_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_out_of_window();
        test_back_to_back();
        test_mixed_order();
        test_backpressure();
        test_proto_err_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obi_hci_responder.md
# obi_hci_responder

OBI subordinate that terminates the CV32E40X core data port (OBI A/R channels, 32-bit address/data, 1-bit RID) and forwards in-window accesses to a single HCI/TCDM initiator port toward L1. Accesses outside the L1 window are granted locally and answered with an error response; no HCI request is issued for them. Responses are returned strictly in order, with up to `N_OUTST` transactions outstanding. The block sits between the core-side OBI crossbar subordinate port for L1 and the HCI log-interconnect core port.

## Interface
Parameters:
- `ADDR_W`, 32, address width (OBI and HCI).
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`.
- `RID_W`, 1, OBI response ID width; A-channel `aid` has the same width and is echoed back.
- `N_OUTST`, 2, maximum outstanding transactions (tag FIFO depth, ≥1).
- `WIN_START`, 32'h1000_0000, inclusive start of the L1 window.
- `WIN_END`, 32'h2000_0000, exclusive end of the L1 window.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `obi_req_i`  in  1  OBI A-channel request.
- `obi_gnt_o`  out  1  OBI grant.
- `obi_addr_i`  in  ADDR_W  byte address.
- `obi_we_i`  in  1  1 = write.
- `obi_be_i`  in  DATA_W/8  byte enables.
- `obi_wdata_i`  in  DATA_W  write data.
- `obi_aid_i`  in  RID_W  transaction ID.
- `obi_rvalid_o`  out  1  response valid. The manager always accepts; there is no rready.
- `obi_rdata_o`  out  DATA_W  read data.
- `obi_rid_o`  out  RID_W  echoed ID.
- `obi_err_o`  out  1  error response.
- `hci_req_o`  out  1  HCI request.
- `hci_gnt_i`  in  1  HCI grant.
- `hci_add_o`  out  ADDR_W  HCI address, equal to `obi_addr_i`.
- `hci_wen_o`  out  1  HCI write-enable-n (1 = read), equal to `~obi_we_i`.
- `hci_be_o`  out  DATA_W/8  equal to `obi_be_i`.
- `hci_data_o`  out  DATA_W  equal to `obi_wdata_i`.
- `hci_r_valid_i`  in  1  HCI response valid, one per granted HCI transaction, reads and writes.
- `hci_r_data_i`  in  DATA_W  HCI read data.
- `proto_err_o`  out  1  sticky flag: `hci_r_valid_i` arrived when no HCI transaction was pending at the FIFO head.

## Operation
- Decode: `in_win = (obi_addr_i >= WIN_START) && (obi_addr_i < WIN_END)`, unsigned 32-bit compare.
- Tag FIFO: depth `N_OUTST`, entries `{rid, we, err}`, with an occupancy counter ranging 0..N_OUTST.
- Combinational A-channel path:
  - `hci_req_o = obi_req_i & in_win & ~full`.
  - `obi_gnt_o = obi_req_i & ~full & (in_win ? hci_gnt_i : 1)`.
- Push: on `obi_req_i & obi_gnt_o`, push `{obi_aid_i, obi_we_i, ~in_win}`.
- No push is allowed when full, even if a pop occurs in the same cycle. This keeps the grant path free of response-side timing.
- Pop, evaluated each cycle on the FIFO head:
  - Head `err=1`: pop unconditionally. Register `rvalid=1`, `err=1`, `rdata=0`, `rid=head.rid`.
  - Head `err=0` and `hci_r_valid_i`: pop. Register `rvalid=1`, `err=0`, `rid=head.rid`, and `rdata = head.we ? 0 : hci_r_data_i`.
  - Otherwise: `rvalid=0`. `rdata`, `rid` and `err` hold their previous values.
- Simultaneous push and pop in the same cycle: occupancy is unchanged.
- Protocol error: `hci_r_valid_i` while the FIFO is empty, or while the head has `err=1`, sets `proto_err_o`. The response is dropped. `proto_err_o` clears only on reset.
- Ordering: HCI returns responses in order. Error entries are interleaved by FIFO position, so OBI responses are always in request order.

## Timing
- Reset state: FIFO empty; `obi_rvalid_o=0`, `obi_rdata_o=0`, `obi_rid_o=0`, `obi_err_o=0`, `proto_err_o=0`.
- After reset, the combinational outputs follow from the reset state: `obi_gnt_o` may be 1 if `obi_req_i` is high.
- Reset asserted mid-operation discards all outstanding tags. Any later stray `hci_r_valid_i` sets `proto_err_o`.
- In-window latency: A-handshake in cycle T, `hci_r_valid_i` at T+1 (TCDM), `obi_rvalid_o` at T+2.
- Out-of-window latency with an empty FIFO: grant at T, `obi_rvalid_o` at T+2.
- Throughput with `N_OUTST=2` and HCI latency 1: one transaction per cycle sustained.
- With `N_OUTST=1`: one transaction every 2 cycles.
- `obi_rvalid_o` is a single-cycle pulse per transaction.
- `obi_addr_i`, `obi_we_i`, `obi_be_i`, `obi_wdata_i` and `obi_aid_i` must be stable while `obi_req_i & ~obi_gnt_o`, per OBI. The block does not check this.

## Test plan
- Single read: read 0x1000_0010 with aid=1, `hci_gnt_i=1`, HCI returns 0xDEAD_BEEF at T+1 → `obi_rvalid_o` at T+2 with rdata 0xDEAD_BEEF, rid=1, err=0.
- Out-of-window access: read 0x2000_0000 → granted at T with `hci_req_o=0`; `obi_rvalid_o` at T+2 with err=1, rdata=0.
- Back-to-back with full FIFO: `N_OUTST=2`, three in-window reads issued while `hci_gnt_i=1` but `hci_r_valid_i` held low → third request is not granted (`obi_gnt_o=0`, `hci_req_o=0`) until the first response pops; then it is granted in the following cycle.
- Mixed ordering: in-window read (aid=0), out-of-window write (aid=1), in-window write (aid=0) → three responses in request order with err 0/1/0; write responses carry rdata 0.
- HCI backpressure: `hci_gnt_i=0` for 3 cycles → `obi_gnt_o=0` and `hci_req_o=1` with stable address; grant passes through on the 4th cycle.
- Protocol error and reset: `hci_r_valid_i` pulsed with the FIFO empty → `proto_err_o=1` and no `obi_rvalid_o`. Then assert `rst_ni=0` asynchronously mid-transaction → all outputs return to reset values immediately.
